// File: rtl/vga_timing_pkg.sv
// Shared raster timing constants and helpers for the VGA timing generator.
// The defaults describe the standard 640x480 mode.
package vga_timing_pkg;

  localparam int DEF_H_ACTIVE = 640;
  localparam int DEF_H_FP     = 16;
  localparam int DEF_H_SYNC   = 96;
  localparam int DEF_H_BP     = 48;
  localparam int DEF_V_ACTIVE = 480;
  localparam int DEF_V_FP     = 10;
  localparam int DEF_V_SYNC   = 2;
  localparam int DEF_V_BP     = 33;

  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // True when val lies in the half-open window [start, start+len).
  function automatic logic in_window(input int val, input int start, input int len);
    return (val >= start) && (val < start + len);
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis counter: counts 0..TOTAL-1 on enable, with a load that
// takes priority over counting. wrap flags the terminal count.
module vga_axis_counter #(
  parameter int TOTAL = 800,
  parameter int W     = 13
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         en,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic [W-1:0] count,
  output logic         wrap
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign wrap = (count == LAST);

  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (load) begin
      count <= load_val;
    end else if (en) begin
      count <= wrap ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised raster timing generator: sync, blanking, data enable,
// look-ahead pixel request, active coordinates, strobes and frame counter.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_ACTIVE = DEF_H_ACTIVE,
  parameter int H_FP     = DEF_H_FP,
  parameter int H_SYNC   = DEF_H_SYNC,
  parameter int H_BP     = DEF_H_BP,
  parameter int V_ACTIVE = DEF_V_ACTIVE,
  parameter int V_FP     = DEF_V_FP,
  parameter int V_SYNC   = DEF_V_SYNC,
  parameter int V_BP     = DEF_V_BP,
  parameter bit HS_POL   = 1'b0,
  parameter bit VS_POL   = 1'b0,
  parameter int REQ_LEAD = 4,
  parameter int RESYNC_H = 0,
  parameter int RESYNC_V = 0,
  parameter int COORD_W  = 13,
  parameter int FRAME_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               pix_en,
  input  logic               resync,
  output logic               hs,
  output logic               vs,
  output logic               blank_n,
  output logic               de,
  output logic               pix_req,
  output logic [COORD_W-1:0] col,
  output logic [COORD_W-1:0] row,
  output logic               line_start,
  output logic               frame_start,
  output logic [FRAME_W-1:0] frame_count
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  localparam logic [COORD_W-1:0] H_ACT_C    = COORD_W'(H_ACTIVE);
  localparam logic [COORD_W-1:0] V_ACT_C    = COORD_W'(V_ACTIVE);
  localparam logic [COORD_W-1:0] REQ_LEAD_C = COORD_W'(REQ_LEAD);
  localparam logic [COORD_W-1:0] REQ_WRAP_C = COORD_W'(H_TOTAL - REQ_LEAD);
  localparam logic [COORD_W-1:0] RES_H_C    = COORD_W'(RESYNC_H);
  localparam logic [COORD_W-1:0] RES_V_C    = COORD_W'(RESYNC_V);

  logic [COORD_W-1:0] h, v;
  logic               h_wrap, v_wrap;
  logic               do_load;

  assign do_load = pix_en & resync;

  vga_axis_counter #(.TOTAL(H_TOTAL), .W(COORD_W)) u_h_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (pix_en),
    .load     (do_load),
    .load_val (RES_H_C),
    .count    (h),
    .wrap     (h_wrap)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL), .W(COORD_W)) u_v_counter (
    .clk      (clk),
    .reset    (reset),
    .en       (pix_en & h_wrap),
    .load     (do_load),
    .load_val (RES_V_C),
    .count    (v),
    .wrap     (v_wrap)
  );

  // Position REQ_LEAD pixels ahead; crossing the line end moves to the next line.
  logic [COORD_W-1:0] h_lead, v_lead;
  logic               active, req_active;

  always_comb begin
    h_lead = h + REQ_LEAD_C;
    v_lead = v;
    if (h >= REQ_WRAP_C) begin
      h_lead = h - REQ_WRAP_C;
      v_lead = v_wrap ? '0 : v + 1'b1;
    end
  end

  assign active     = (h < H_ACT_C) && (v < V_ACT_C);
  assign req_active = (h_lead < H_ACT_C) && (v_lead < V_ACT_C);

  always_ff @(posedge clk) begin
    if (reset) begin
      hs          <= ~HS_POL;
      vs          <= ~VS_POL;
      blank_n     <= 1'b0;
      de          <= 1'b0;
      pix_req     <= 1'b0;
      col         <= '0;
      row         <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end else if (pix_en) begin
      hs          <= in_window(int'(h), H_ACTIVE + H_FP, H_SYNC) ? HS_POL : ~HS_POL;
      vs          <= in_window(int'(v), V_ACTIVE + V_FP, V_SYNC) ? VS_POL : ~VS_POL;
      blank_n     <= active;
      de          <= active;
      pix_req     <= req_active;
      col         <= active ? h : '0;
      row         <= active ? v : '0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
    end else begin
      line_start  <= 1'b0;
      frame_start <= 1'b0;
    end
  end

  // A resync on the wrap cycle replaces the wrap, so the frame is not counted.
  always_ff @(posedge clk) begin
    if (reset) begin
      frame_count <= '0;
    end else if (pix_en && !resync && h_wrap && v_wrap) begin
      frame_count <= frame_count + 1'b1;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen on a small 14x7 raster, checked against a
// position-based reference model of the raster rules.
module tb_vga_timing_gen;

  localparam int HA = 8, HF = 2, HSW = 2, HB = 2;
  localparam int VA = 4, VF = 1, VSW = 1, VB = 1;
  localparam int RL = 2, RH = 5, RV = 3;
  localparam int CW = 13, FW = 2;
  localparam int HT = HA + HF + HSW + HB;
  localparam int VT = VA + VF + VSW + VB;
  localparam int FRAME = HT * VT;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pix_en = 1'b0;
  logic          resync = 1'b0;
  logic          hs, vs, blank_n, de, pix_req, line_start, frame_start;
  logic [CW-1:0] col, row;
  logic [FW-1:0] frame_count;

  int vectors = 0;
  int miscompares = 0;

  vga_timing_gen #(
    .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HSW), .H_BP(HB),
    .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VSW), .V_BP(VB),
    .HS_POL(1'b0), .VS_POL(1'b0), .REQ_LEAD(RL),
    .RESYNC_H(RH), .RESYNC_V(RV), .COORD_W(CW), .FRAME_W(FW)
  ) dut (
    .clk(clk), .reset(reset), .pix_en(pix_en), .resync(resync),
    .hs(hs), .vs(vs), .blank_n(blank_n), .de(de), .pix_req(pix_req),
    .col(col), .row(row), .line_start(line_start), .frame_start(frame_start),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  // {hs, vs, blank_n, de, pix_req, col, row, line_start, frame_start, frame_count}
  typedef logic [4+CW+CW+2+FW:0] obs_t;

  int   mh = 0, mv = 0, mfc = 0;
  obs_t m_out;

  function automatic obs_t ref_out(input int h, input int v, input int fc);
    logic act, req, hsa, vsa;
    logic [CW-1:0] c, r;
    logic [FW-1:0] f;
    int hp, vp;
    hsa = (h >= HA + HF) && (h < HA + HF + HSW);
    vsa = (v >= VA + VF) && (v < VA + VF + VSW);
    act = (h < HA) && (v < VA);
    hp = h + RL;
    vp = v;
    if (hp >= HT) begin
      hp = hp - HT;
      vp = (v + 1) % VT;
    end
    req = (hp < HA) && (vp < VA);
    c = act ? CW'(h) : '0;
    r = act ? CW'(v) : '0;
    f = FW'(fc);
    return {~hsa, ~vsa, act, act, req, c, r, (h == 0), (h == 0 && v == 0), f};
  endfunction

  function automatic obs_t reset_out();
    obs_t o;
    o = '0;
    o[4+CW+CW+2+FW] = 1'b1;
    o[3+CW+CW+2+FW] = 1'b1;
    return o;
  endfunction

  function automatic obs_t got_out();
    return {hs, vs, blank_n, de, pix_req, col, row, line_start, frame_start, frame_count};
  endfunction

  // Apply one clock of stimulus and advance the reference model with it.
  task automatic advance(input logic pe, input logic rs, input logic rst);
    @(negedge clk);
    pix_en = pe;
    resync = rs;
    reset  = rst;
    @(posedge clk);
    if (rst) begin
      mh = 0; mv = 0; mfc = 0;
      m_out = reset_out();
    end else if (pe) begin
      m_out = ref_out(mh, mv, mfc);
      if (rs) begin
        mh = RH; mv = RV;
      end else if (mh == HT - 1) begin
        mh = 0;
        if (mv == VT - 1) begin
          mv = 0;
          mfc = (mfc + 1) % (1 << FW);
        end else begin
          mv = mv + 1;
        end
      end else begin
        mh = mh + 1;
      end
      m_out[FW-1:0] = FW'(mfc);
    end else begin
      m_out[FW+1:FW] = 2'b00;
    end
    #1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      advance(1'b1, 1'b0, 1'b1);
      vectors++;
      if (got_out() !== reset_out()) begin
        miscompares++;
        $display("FAIL reset_state got=%h exp=%h", got_out(), reset_out());
      end
    end
  endtask

  task automatic test_free_run();
    int last_fs = -1;
    int req_cnt = 0;
    for (int i = 0; i < 2 * FRAME + 5; i++) begin
      advance(1'b1, 1'b0, 1'b0);
      vectors++;
      if (got_out() !== m_out) begin
        miscompares++;
        $display("FAIL free_run cyc=%0d got=%h exp=%h", i, got_out(), m_out);
      end
      if (i >= FRAME && i < 2 * FRAME && pix_req === 1'b1) req_cnt++;
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          vectors++;
          if (i - last_fs != FRAME) begin
            miscompares++;
            $display("FAIL frame_period got=%0d exp=%0d", i - last_fs, FRAME);
          end
        end
        last_fs = i;
      end
    end
    vectors++;
    if (req_cnt != HA * VA) begin
      miscompares++;
      $display("FAIL req_per_frame got=%0d exp=%0d", req_cnt, HA * VA);
    end
  endtask

  task automatic test_pix_en_toggle();
    int last_fs = -1;
    int periods = 0;
    for (int i = 0; i < 2 * 2 * FRAME + 4; i++) begin
      advance(logic'(i % 2 == 0), 1'b0, 1'b0);
      vectors++;
      if (got_out() !== m_out) begin
        miscompares++;
        $display("FAIL toggle cyc=%0d got=%h exp=%h", i, got_out(), m_out);
      end
      if (frame_start === 1'b1) begin
        if (last_fs >= 0) begin
          periods++;
          vectors++;
          if (i - last_fs != 2 * FRAME) begin
            miscompares++;
            $display("FAIL toggle_period got=%0d exp=%0d", i - last_fs, 2 * FRAME);
          end
        end
        last_fs = i;
      end
    end
    vectors++;
    if (periods < 1) begin
      miscompares++;
      $display("FAIL toggle_periods got=%0d exp>=1", periods);
    end
    for (int i = 0; i < 300; i++) begin
      advance(logic'($urandom_range(0, 3) != 0), 1'b0, 1'b0);
      vectors++;
      if (got_out() !== m_out) begin
        miscompares++;
        $display("FAIL random_en cyc=%0d got=%h exp=%h", i, got_out(), m_out);
      end
    end
  endtask

  // Run with pix_en=1 until the model reaches (th, tv), then pulse resync there.
  task automatic resync_at(input int th, input int tv, input string name);
    int n = 0;
    while (!(mh == th && mv == tv) && n < 4 * FRAME) begin
      advance(1'b1, 1'b0, 1'b0);
      n++;
    end
    vectors++;
    if (n >= 4 * FRAME) begin
      miscompares++;
      $display("FAIL %s_timeout got=%0d,%0d exp=%0d,%0d", name, mh, mv, th, tv);
    end
    for (int i = 0; i < 20; i++) begin
      advance(1'b1, logic'(i == 0), 1'b0);
      vectors++;
      if (got_out() !== m_out) begin
        miscompares++;
        $display("FAIL %s cyc=%0d got=%h exp=%h", name, i, got_out(), m_out);
      end
    end
  endtask

  task automatic test_resync();
    resync_at(0, 0, "resync_origin");
    resync_at(HT - 1, VT - 1, "resync_wrap");
    for (int i = 0; i < 400; i++) begin
      advance(logic'($urandom_range(0, 4) != 0), logic'($urandom_range(0, 60) == 0), 1'b0);
      vectors++;
      if (got_out() !== m_out) begin
        miscompares++;
        $display("FAIL resync_random cyc=%0d got=%h exp=%h", i, got_out(), m_out);
      end
    end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(mh == 9 && mv == 2) && n < 4 * FRAME) begin
      advance(1'b1, 1'b0, 1'b0);
      n++;
    end
    advance(1'b1, 1'b0, 1'b1);
    vectors++;
    if (got_out() !== reset_out()) begin
      miscompares++;
      $display("FAIL reset_mid got=%h exp=%h", got_out(), reset_out());
    end
    advance(1'b1, 1'b0, 1'b0);
    vectors++;
    if (frame_start !== 1'b1 || line_start !== 1'b1 || de !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release got fs=%b ls=%b de=%b exp=1,1,1", frame_start, line_start, de);
    end
  endtask

  task automatic test_frame_count();
    logic [FW-1:0] seq [6];
    int k = 0;
    seq[0] = 2'd0; seq[1] = 2'd1; seq[2] = 2'd2; seq[3] = 2'd3; seq[4] = 2'd0; seq[5] = 2'd1;
    advance(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 5 * FRAME + 10 && k < 6; i++) begin
      advance(1'b1, 1'b0, 1'b0);
      if (frame_start === 1'b1) begin
        vectors++;
        if (frame_count !== seq[k]) begin
          miscompares++;
          $display("FAIL frame_count idx=%0d got=%0d exp=%0d", k, frame_count, seq[k]);
        end
        k++;
      end
    end
    vectors++;
    if (k != 6) begin
      miscompares++;
      $display("FAIL frame_count_starts got=%0d exp=6", k);
    end
  endtask

  initial begin
    m_out = reset_out();
    test_reset();
    test_free_run();
    test_pix_en_toggle();
    test_resync();
    test_reset_mid();
    test_frame_count();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
